// File: rtl/can_tx_frame_serializer_if.sv
// Message-buffer side of the CAN transmit serializer: frame request fields in, serial bit and status out.
interface can_tx_frame_serializer_if;
  logic        bit_en;
  logic        start;
  logic [10:0] id;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        ready;
  logic        tx;
  logic        done;
  logic [14:0] crc_out;

  modport master (output bit_en, start, id, rtr, dlc, data, input ready, tx, done, crc_out);
  modport slave  (input bit_en, start, id, rtr, dlc, data, output ready, tx, done, crc_out);
endinterface

// File: rtl/can_tx_frame_serializer.sv
// CAN 2.0A standard frame transmitter: one bit per bit_en strobe, internal CRC-15 and bit stuffing.
module can_tx_frame_serializer #(
  parameter logic [14:0] CRC_POLY = 15'h4599,
  parameter int          IFS_BITS = 3
) (
  input logic                     clk,
  input logic                     rst,
  can_tx_frame_serializer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS} state_t;

  state_t      state;
  logic [63:0] sr, data_r;
  logic [3:0]  dlc_r;
  logic        rtr_r;
  logic [6:0]  cnt;
  logic [2:0]  run;
  logic [14:0] crc, crc_out_r;
  logic        tx_r, ready_r, done_r;
  logic        nb, stuff_now, last_bit, no_data;
  logic [14:0] crc_nx;
  logic [6:0]  data_last;

  assign bus.tx      = tx_r;
  assign bus.ready   = ready_r;
  assign bus.done    = done_r;
  assign bus.crc_out = crc_out_r;

  // Every shifted field is left-aligned in sr, so the next field bit is always sr[63].
  always_comb begin
    nb = 1'b1;
    case (state)
      SOF:                  nb = 1'b0;
      ARB, CTRL, DATA, CRC: nb = sr[63];
      default:              nb = 1'b1;
    endcase
  end

  // CRC_DEL is included so a run completed by the last CRC bit still gets its stuff bit.
  assign stuff_now = (run == 3'd5) && (state inside {ARB, CTRL, DATA, CRC, CRC_DEL});
  assign last_bit  = (cnt == 7'd0);
  assign crc_nx    = {crc[13:0], 1'b0} ^ ((nb ^ crc[14]) ? CRC_POLY : 15'd0);
  assign no_data   = rtr_r || (dlc_r == 4'd0);
  assign data_last = dlc_r[3] ? 7'd63 : ({1'b0, dlc_r[2:0], 3'b000} - 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      data_r    <= '0;
      dlc_r     <= '0;
      rtr_r     <= 1'b0;
      cnt       <= '0;
      run       <= '0;
      crc       <= '0;
      crc_out_r <= '0;
      tx_r      <= 1'b1;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          data_r  <= bus.data;
          dlc_r   <= bus.dlc;
          rtr_r   <= bus.rtr;
          sr      <= {bus.id, bus.rtr, 52'd0};
          cnt     <= 7'd11;
          crc     <= '0;
          ready_r <= 1'b0;
          // SOF is dominant and leaves a zero CRC unchanged, so it can go out on the accept edge.
          if (bus.bit_en) begin
            tx_r  <= 1'b0;
            run   <= 3'd1;
            state <= ARB;
          end else begin
            state <= SOF;
          end
        end
      end else if (bus.bit_en) begin
        if (stuff_now) begin
          tx_r <= ~tx_r;
          run  <= 3'd1;
        end else begin
          tx_r <= nb;
          run  <= (nb == tx_r && run != 3'd7) ? run + 3'd1 : 3'd1;
          if (state inside {SOF, ARB, CTRL, DATA}) crc <= crc_nx;
          sr  <= {sr[62:0], 1'b0};
          cnt <= cnt - 7'd1;
          case (state)
            SOF: begin
              sr    <= sr;
              cnt   <= cnt;
              run   <= 3'd1;
              state <= ARB;
            end
            ARB: if (last_bit) begin
              state <= CTRL;
              cnt   <= 7'd5;
              sr    <= {2'b00, dlc_r, 58'd0};
            end
            CTRL: if (last_bit) begin
              if (no_data) begin
                state     <= CRC;
                cnt       <= 7'd14;
                sr        <= {crc_nx, 49'd0};
                crc_out_r <= crc_nx;
              end else begin
                state <= DATA;
                cnt   <= data_last;
                sr    <= data_r;
              end
            end
            DATA: if (last_bit) begin
              state     <= CRC;
              cnt       <= 7'd14;
              sr        <= {crc_nx, 49'd0};
              crc_out_r <= crc_nx;
            end
            CRC:     if (last_bit) state <= CRC_DEL;
            CRC_DEL: state <= ACK;
            ACK:     state <= ACK_DEL;
            ACK_DEL: begin
              state <= EOF;
              cnt   <= 7'd6;
            end
            EOF: if (last_bit) begin
              state <= IFS;
              cnt   <= 7'(IFS_BITS);
            end
            // One extra strobe in IFS: the edge that ends the last intermission bit.
            IFS: if (last_bit) begin
              state   <= IDLE;
              ready_r <= 1'b1;
              done_r  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule
